rec_tran: RTL and testbench

REC_TRAN -- requirements
Module: rec_tran

---
 rtl/rec_tran.sv | 200 ++++++++++++++++++++
 tb/tb_rec_tran.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_tran.sv
// rec_tran: serial frame receiver. Hunts for the 6-byte FAS on the incoming line, then
// deserializes the payload bytes. With ARQ enabled it waits for the downstream frame check
// and returns a start/result/stop acknowledgement on the ACK line.
module rec_tran #(
    parameter int unsigned FRAME_BYTES = 4165,
    parameter int unsigned BAUD_DIV    = 20,
    parameter int unsigned SAMPLE_PT   = 9
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk_en_16_x_baud,
    input  logic       i_otn_rx_data,
    output logic [7:0] o_frame_data,
    output logic       o_frame_data_valid,
    output logic       o_frame_data_fas,
    input  logic       i_frame_check_done,
    input  logic       i_frame_check_ok,
    output logic       o_otn_tx_ack,
    output logic       o_frame_lock,
    input  logic       i_arq_en
);

    // FAS bytes F6,F6,F6,28,28,28 received LSB first; first byte lands in bits [7:0].
    localparam logic [47:0] FAS_PATTERN = 48'h2828_28F6_F6F6;
    localparam logic [4:0]  BIT_LAST    = 5'(BAUD_DIV - 1);
    localparam logic [4:0]  SAMPLE_AT   = 5'(SAMPLE_PT);
    localparam logic [12:0] LAST_BYTE   = 13'(FRAME_BYTES - 7);

    typedef enum logic [2:0] {
        StHunt,
        StReceive,
        StCheckWait,
        StAckStart,
        StAckBit,
        StAckStop
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_last;
    logic [4:0]  r_rx_timer;
    logic [4:0]  r_tx_timer;
    logic [47:0] r_hunt_sr;
    logic [7:0]  r_byte_sr;
    logic [2:0]  r_bit_cnt;
    logic [12:0] r_byte_cnt;
    logic        r_ok;
    logic        r_ack;
    logic [7:0]  r_frame_data;
    logic        r_frame_valid;
    logic        r_frame_fas;

    logic        w_rx_edge;
    logic        w_sample;
    logic [47:0] w_hunt_shift;
    logic [7:0]  w_byte_shift;
    logic        w_fas_hit;
    logic        w_byte_done;
    logic        w_frame_end;
    logic        w_tx_wrap;
    logic        w_in_ack;
    logic        w_ack_next;

    assign w_rx_edge    = i_sclk_en_16_x_baud && (r_rx_sync != r_rx_last);
    assign w_sample     = i_sclk_en_16_x_baud && (r_rx_timer == SAMPLE_AT);
    assign w_hunt_shift = {r_rx_sync, r_hunt_sr[47:1]};
    assign w_byte_shift = {r_rx_sync, r_byte_sr[7:1]};
    assign w_fas_hit    = (r_state == StHunt) && w_sample && (w_hunt_shift == FAS_PATTERN);
    assign w_byte_done  = (r_state == StReceive) && w_sample && (r_bit_cnt == 3'd7);
    assign w_frame_end  = w_byte_done && (r_byte_cnt == LAST_BYTE);
    assign w_tx_wrap    = i_sclk_en_16_x_baud && (r_tx_timer == BIT_LAST);
    assign w_in_ack     = (r_state == StAckStart) || (r_state == StAckBit)
                          || (r_state == StAckStop);

    assign o_frame_data       = r_frame_data;
    assign o_frame_data_valid = r_frame_valid;
    assign o_frame_data_fas   = r_frame_fas;
    assign o_otn_tx_ack       = r_ack;
    assign o_frame_lock       = (r_state == StReceive);

    // Line synchronizer; r_rx_last is the synchronized bit as seen at the previous enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta <= 1'b0;
            r_rx_sync <= 1'b0;
            r_rx_last <= 1'b0;
        end else begin
            r_rx_meta <= i_otn_rx_data;
            r_rx_sync <= r_rx_meta;
            if (i_sclk_en_16_x_baud) begin
                r_rx_last <= r_rx_sync;
            end
        end
    end

    // Rx bit timer: free-running per bit, re-phased on every line transition.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_timer <= 5'd0;
        end else if (i_sclk_en_16_x_baud) begin
            if (w_rx_edge || (r_rx_timer == BIT_LAST)) begin
                r_rx_timer <= 5'd0;
            end else begin
                r_rx_timer <= r_rx_timer + 5'd1;
            end
        end
    end

    // Next-state and ACK line value for the state being entered.
    always_comb begin
        w_state_next = r_state;
        w_ack_next   = 1'b1;
        unique case (r_state)
            StHunt:      if (w_fas_hit) w_state_next = StReceive;
            StReceive:   if (w_frame_end) w_state_next = i_arq_en ? StCheckWait : StHunt;
            StCheckWait: if (i_frame_check_done) w_state_next = StAckStart;
            StAckStart:  if (w_tx_wrap) w_state_next = StAckBit;
            StAckBit:    if (w_tx_wrap) w_state_next = StAckStop;
            StAckStop:   if (w_tx_wrap) w_state_next = StHunt;
            default:     w_state_next = StHunt;
        endcase
        unique case (w_state_next)
            StAckStart: w_ack_next = 1'b0;
            StAckBit:   w_ack_next = r_ok;
            StAckStop:  w_ack_next = 1'b0;
            default:    w_ack_next = 1'b1;
        endcase
    end

    // State register, ACK line, check result latch and tx bit timer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StHunt;
            r_ack      <= 1'b1;
            r_ok       <= 1'b0;
            r_tx_timer <= 5'd0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            if ((r_state == StCheckWait) && i_frame_check_done) begin
                r_ok <= i_frame_check_ok;
            end
            // Wrapping at BIT_LAST leaves the timer at 0 for each following ACK state.
            if (!w_in_ack) begin
                r_tx_timer <= 5'd0;
            end else if (i_sclk_en_16_x_baud) begin
                r_tx_timer <= w_tx_wrap ? 5'd0 : r_tx_timer + 5'd1;
            end
        end
    end

    // FAS hunt shift register; held clear outside HUNT so each hunt starts empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hunt_sr <= 48'd0;
        end else if (r_state != StHunt) begin
            r_hunt_sr <= 48'd0;
        end else if (w_sample) begin
            r_hunt_sr <= w_hunt_shift;
        end
    end

    // Payload deserializer with bit and byte counters, cleared outside RECEIVE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_sr  <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 13'd0;
        end else if (r_state != StReceive) begin
            r_byte_sr  <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 13'd0;
        end else if (w_sample) begin
            r_byte_sr <= w_byte_shift;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
                r_byte_cnt <= r_byte_cnt + 13'd1;
            end
        end
    end

    // Output byte and one-cycle strobes; the byte holds between strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_data  <= 8'd0;
            r_frame_valid <= 1'b0;
            r_frame_fas   <= 1'b0;
        end else begin
            r_frame_valid <= w_byte_done;
            r_frame_fas   <= w_fas_hit;
            if (w_byte_done) begin
                r_frame_data <= w_byte_shift;
            end
        end
    end

endmodule

// File: tb/tb_rec_tran.sv
// Randomized bench for rec_tran: the bench acts as the serial sender, keeps a queue of
// expected payload bytes and a run-length model of the ACK waveform.
module tb_rec_tran;

    localparam int unsigned FRAME_BYTES = 26;
    localparam int unsigned BAUD_DIV    = 20;
    localparam int unsigned SAMPLE_PT   = 9;
    localparam int          PAYLOAD     = FRAME_BYTES - 6;

    logic       i_clk;
    logic       i_rst;
    logic       i_sclk_en_16_x_baud;
    logic       i_otn_rx_data;
    logic [7:0] o_frame_data;
    logic       o_frame_data_valid;
    logic       o_frame_data_fas;
    logic       i_frame_check_done;
    logic       i_frame_check_ok;
    logic       o_otn_tx_ack;
    logic       o_frame_lock;
    logic       i_arq_en;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fas    = 0;
    int         n_valid  = 0;
    int         n_ack_low = 0;
    logic [7:0] exp_q[$];
    logic [7:0] payload[PAYLOAD];

    rec_tran #(
        .FRAME_BYTES(FRAME_BYTES),
        .BAUD_DIV   (BAUD_DIV),
        .SAMPLE_PT  (SAMPLE_PT)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_sclk_en_16_x_baud(i_sclk_en_16_x_baud),
        .i_otn_rx_data      (i_otn_rx_data),
        .o_frame_data       (o_frame_data),
        .o_frame_data_valid (o_frame_data_valid),
        .o_frame_data_fas   (o_frame_data_fas),
        .i_frame_check_done (i_frame_check_done),
        .i_frame_check_ok   (i_frame_check_ok),
        .o_otn_tx_ack       (o_otn_tx_ack),
        .o_frame_lock       (o_frame_lock),
        .i_arq_en           (i_arq_en)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Hold the line at b for one serial bit (BAUD_DIV enables, enables randomly gapped).
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        i_otn_rx_data = b;
        while (n < int'(BAUD_DIV)) begin
            i_sclk_en_16_x_baud = ($urandom_range(0, 7) != 0);
            if (i_sclk_en_16_x_baud) n++;
            step();
        end
    endtask

    task automatic idle_enables(input int cnt);
        int n;
        n = 0;
        while (n < cnt) begin
            i_sclk_en_16_x_baud = ($urandom_range(0, 7) != 0);
            if (i_sclk_en_16_x_baud) n++;
            step();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_fas();
        for (int k = 0; k < 6; k++) send_byte((k < 3) ? 8'hF6 : 8'h28);
    endtask

    // Queue the whole payload as expected, then send idle, FAS and the first n_send bytes.
    // i_arq_en wanders randomly mid-frame and only takes arq_final for the last byte.
    task automatic send_frame(input logic arq_final, input int n_send);
        for (int i = 0; i < PAYLOAD; i++) exp_q.push_back(payload[i]);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        send_fas();
        for (int j = 0; j < n_send; j++) begin
            i_arq_en = (j == PAYLOAD - 1) ? arq_final : 1'($urandom_range(0, 1));
            send_byte(payload[j]);
        end
        step();
        step();
    endtask

    task automatic fill_random();
        for (int i = 0; i < PAYLOAD; i++) payload[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic frame_checks(input string tag, input int fas0, input int valid0);
        check_eq({tag, "_fas_count"}, n_fas - fas0, 1);
        check_eq({tag, "_byte_count"}, n_valid - valid0, PAYLOAD);
        check_eq({tag, "_bytes_left"}, exp_q.size(), 0);
        check_eq({tag, "_lock_after"}, o_frame_lock, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data"}, o_frame_data, 0);
        check_eq({tag, "_valid"}, o_frame_data_valid, 0);
        check_eq({tag, "_fas"}, o_frame_data_fas, 0);
        check_eq({tag, "_lock"}, o_frame_lock, 0);
        check_eq({tag, "_ack"}, o_otn_tx_ack, 1);
    endtask

    // Pulse the frame check result and compare the ACK waveform, sampled per enable,
    // against its run-length model: ok -> 0/1/0 for BAUD_DIV each, bad -> 0 for 3*BAUD_DIV.
    task automatic do_ack(input logic ok_val);
        logic smp[$];
        int   act_len[$];
        logic act_val[$];
        int   exp_len[$];
        logic exp_val[$];
        int   guard;
        int   nw;
        nw = $urandom_range(1, 10);
        for (int i = 0; i < nw; i++) begin
            i_sclk_en_16_x_baud = ($urandom_range(0, 7) != 0);
            step();
        end
        check_eq("ack_idle_before_check", o_otn_tx_ack, 1);
        check_eq("lock_in_check_wait", o_frame_lock, 0);
        i_frame_check_done  = 1'b1;
        i_frame_check_ok    = ok_val;
        i_sclk_en_16_x_baud = 1'b0;
        step();
        i_frame_check_done = 1'b0;
        i_frame_check_ok   = 1'($urandom_range(0, 1));
        guard = 0;
        while (smp.size() < 4 * BAUD_DIV && guard < 1000) begin
            i_sclk_en_16_x_baud = ($urandom_range(0, 7) != 0);
            if (i_sclk_en_16_x_baud) smp.push_back(o_otn_tx_ack);
            step();
            guard++;
        end
        check_eq("ack_sample_budget", smp.size(), 4 * BAUD_DIV);
        foreach (smp[i]) begin
            if (act_val.size() == 0 || act_val[act_val.size() - 1] != smp[i]) begin
                act_val.push_back(smp[i]);
                act_len.push_back(1);
            end else begin
                act_len[act_len.size() - 1]++;
            end
        end
        if (ok_val) begin
            exp_len = '{BAUD_DIV, BAUD_DIV, BAUD_DIV, BAUD_DIV};
            exp_val = '{1'b0, 1'b1, 1'b0, 1'b1};
        end else begin
            exp_len = '{3 * BAUD_DIV, BAUD_DIV};
            exp_val = '{1'b0, 1'b1};
        end
        check_eq("ack_run_count", act_len.size(), exp_len.size());
        for (int i = 0; i < exp_len.size() && i < act_len.size(); i++) begin
            check_eq($sformatf("ack_run%0d_level", i), act_val[i], exp_val[i]);
            check_eq($sformatf("ack_run%0d_enables", i), act_len[i], exp_len[i]);
        end
    endtask

    // Output monitor: counts strobes, matches bytes against the expected queue,
    // and checks the data hold and strobe exclusivity rules.
    initial begin
        logic       prev_rst;
        logic [7:0] last_data;
        prev_rst  = 1'b1;
        last_data = 8'h00;
        forever begin
            @(negedge i_clk);
            if (o_frame_data_fas) n_fas++;
            if (!o_otn_tx_ack) n_ack_low++;
            if (o_frame_data_valid) begin
                n_valid++;
                check_eq("fas_with_valid", o_frame_data_fas, 0);
                if (exp_q.size() > 0) check_eq("payload_byte", o_frame_data, exp_q.pop_front());
                else check_eq("unexpected_byte_queue", exp_q.size(), 1);
            end else if (!prev_rst && o_frame_data !== last_data) begin
                check_eq("data_hold", o_frame_data, last_data);
            end
            last_data = o_frame_data;
            prev_rst  = i_rst;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", n_pass,
                 n_checks);
        $fatal(1);
    end

    initial begin
        int fas0;
        int valid0;
        int ack0;

        i_rst               = 1'b1;
        i_sclk_en_16_x_baud = 1'b0;
        i_otn_rx_data       = 1'b1;
        i_frame_check_done  = 1'b0;
        i_frame_check_ok    = 1'b0;
        i_arq_en            = 1'b0;

        // Reset with the line toggling.
        for (int i = 0; i < 20; i++) begin
            i_sclk_en_16_x_baud = ($urandom_range(0, 7) != 0);
            i_otn_rx_data       = 1'($urandom_range(0, 1));
            step();
        end
        check_reset_outputs("reset_init");
        check_eq("reset_no_fas", n_fas, 0);
        check_eq("reset_no_valid", n_valid, 0);
        i_rst         = 1'b0;
        i_otn_rx_data = 1'b1;

        // No ARQ, bytes n mod 256.
        for (int i = 0; i < PAYLOAD; i++) payload[i] = 8'(i % 256);
        fas0 = n_fas; valid0 = n_valid; ack0 = n_ack_low;
        send_frame(1'b0, PAYLOAD);
        frame_checks("noarq", fas0, valid0);
        for (int i = 0; i < 30; i++) begin
            i_sclk_en_16_x_baud = ($urandom_range(0, 7) != 0);
            step();
        end
        check_eq("noarq_ack_stays_high", n_ack_low - ack0, 0);

        // A check-done pulse while hunting must not start an ACK.
        ack0 = n_ack_low;
        i_frame_check_done = 1'b1;
        i_frame_check_ok   = 1'b1;
        step();
        i_frame_check_done = 1'b0;
        idle_enables(3 * BAUD_DIV + 5);
        check_eq("done_in_hunt_ignored", n_ack_low - ack0, 0);

        // ARQ, good frame; a FAS sent while waiting for the check must be ignored.
        fill_random();
        fas0 = n_fas; valid0 = n_valid;
        send_frame(1'b1, PAYLOAD);
        frame_checks("arq_good", fas0, valid0);
        fas0 = n_fas;
        send_fas();
        check_eq("fas_ignored_in_check_wait", n_fas - fas0, 0);
        check_eq("lock_low_in_check_wait", o_frame_lock, 0);
        do_ack(1'b1);

        // ARQ, bad frame then retransmission.
        fill_random();
        fas0 = n_fas; valid0 = n_valid;
        send_frame(1'b1, PAYLOAD);
        frame_checks("arq_bad", fas0, valid0);
        do_ack(1'b0);
        fas0 = n_fas; valid0 = n_valid;
        send_frame(1'b0, PAYLOAD);
        frame_checks("resend", fas0, valid0);

        // Corrupted FAS and junk, sender phase shifted, then a valid frame.
        fas0 = n_fas; valid0 = n_valid;
        idle_enables(7);
        for (int k = 0; k < 6; k++) send_byte((k < 3) ? 8'hF6 : ((k < 5) ? 8'h28 : 8'h27));
        check_eq("bad_fas_no_lock", n_fas - fas0, 0);
        check_eq("bad_fas_lock_low", o_frame_lock, 0);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(0, 255)));
        check_eq("junk_no_lock", n_fas - fas0, 0);
        fill_random();
        send_frame(1'b0, PAYLOAD);
        frame_checks("after_junk", fas0, valid0);

        // Reset after 10 payload bytes, then a full frame.
        fill_random();
        fas0 = n_fas; valid0 = n_valid;
        send_frame(1'b0, 10);
        check_eq("partial_bytes", n_valid - valid0, 10);
        check_eq("partial_locked", o_frame_lock, 1);
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_sclk_en_16_x_baud = ($urandom_range(0, 7) != 0);
            i_otn_rx_data       = 1'($urandom_range(0, 1));
            step();
        end
        exp_q.delete();
        check_reset_outputs("reset_mid_frame");
        i_rst         = 1'b0;
        i_otn_rx_data = 1'b1;
        fill_random();
        fas0 = n_fas; valid0 = n_valid;
        send_frame(1'b0, PAYLOAD);
        frame_checks("after_reset", fas0, valid0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
